// File: rtl/rate_timer.sv
// rate_timer: square-wave rate generator at BASE_HZ * 2^spe with pause, phase restart and boundary-aligned rate changes
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active-high
//   en        in   1 = run, 0 = pause (all state held)
//   clr       in   synchronous phase restart; loads spe into spe_act
//   spe       in   requested speed select (SEL_W bits)
//   clk_out   out  square-wave output, low first after reset/clr
//   tick      out  one-cycle strobe coincident with each rising clk_out
//   spe_act   out  speed select currently in effect
//   beat_cnt  out  completed full periods, wrapping (BEAT_W bits)
module rate_timer #(
    parameter int CLK_HZ  = 50000000,
    parameter int BASE_HZ = 1,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 32,
    parameter int BEAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [SEL_W-1:0]  spe,
    output logic              clk_out,
    output logic              tick,
    output logic [SEL_W-1:0]  spe_act,
    output logic [BEAT_W-1:0] beat_cnt
);

    // 64-bit so the range check against 2^CNT_W is meaningful for CNT_W = 32
    localparam logic [63:0] HALF_BASE = 64'(CLK_HZ) / (64'd2 * 64'(BASE_HZ));

    if ((HALF_BASE >> ((1 << SEL_W) - 1)) < 64'd1) begin : g_bad_fast
        $error("rate_timer: fastest half-period is shorter than one clock");
    end
    if (HALF_BASE >= (64'd1 << CNT_W)) begin : g_bad_cnt
        $error("rate_timer: HALF_BASE does not fit in CNT_W bits");
    end

    logic [CNT_W-1:0]  r_cnt;
    logic              r_clk_out;
    logic              r_tick;
    logic [SEL_W-1:0]  r_spe_act;
    logic [BEAT_W-1:0] r_beat;
    logic [CNT_W-1:0]  w_last;
    logic              w_term;

    // Half-period length follows spe_act only, so a new spe waits for the boundary
    assign w_last = CNT_W'(HALF_BASE >> r_spe_act) - CNT_W'(1);
    assign w_term = (r_cnt == w_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_spe_act <= '0;
            r_beat    <= '0;
        end else if (clr) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_spe_act <= spe;
        end else if (en) begin
            r_tick <= w_term & ~r_clk_out;
            if (w_term) begin
                r_cnt     <= '0;
                r_clk_out <= ~r_clk_out;
                r_spe_act <= spe;
                if (!r_clk_out)
                    r_beat <= r_beat + BEAT_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign clk_out  = r_clk_out;
    assign tick     = r_tick;
    assign spe_act  = r_spe_act;
    assign beat_cnt = r_beat;

endmodule

// File: tb/tb_rate_timer.sv
// tb_rate_timer: table-driven, hand-sequenced and randomized checks of rate_timer against a behavioural model
module tb_rate_timer;

    localparam int CLK_HZ  = 16;
    localparam int BASE_HZ = 1;
    localparam int SEL_W   = 2;
    localparam int CNT_W   = 8;
    localparam int BEAT_W  = 4;
    localparam int HB      = CLK_HZ / (2 * BASE_HZ);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en  = 1'b0;
    logic              clr = 1'b0;
    logic [SEL_W-1:0]  spe = '0;
    logic              clk_out;
    logic              tick;
    logic [SEL_W-1:0]  spe_act;
    logic [BEAT_W-1:0] beat_cnt;

    int errors = 0;
    int checks = 0;

    // Model state: position inside the current half-period, level, and period count
    int m_pos, m_lvl, m_tick, m_act, m_beat;

    rate_timer #(
        .CLK_HZ(CLK_HZ), .BASE_HZ(BASE_HZ), .SEL_W(SEL_W), .CNT_W(CNT_W), .BEAT_W(BEAT_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .spe(spe),
        .clk_out(clk_out), .tick(tick), .spe_act(spe_act), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       e;
        logic       c;
        logic [1:0] s;
        int         n;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic model_step(input logic r, input logic e, input logic c, input int s);
        if (r) begin
            m_pos = 0; m_lvl = 0; m_tick = 0; m_act = 0; m_beat = 0;
        end else if (c) begin
            m_pos = 0; m_lvl = 0; m_tick = 0; m_act = s;
        end else if (e) begin
            m_tick = 0;
            m_pos++;
            if (m_pos == (HB >> m_act)) begin
                m_pos = 0;
                m_lvl = 1 - m_lvl;
                m_act = s;
                if (m_lvl == 1) begin
                    m_tick = 1;
                    m_beat = (m_beat + 1) % (1 << BEAT_W);
                end
            end
        end else begin
            m_tick = 0;
        end
    endtask

    task automatic run(input logic r, input logic e, input logic c, input logic [1:0] s, input int n);
        for (int k = 0; k < n; k++) begin
            rst = r; en = e; clr = c; spe = s;
            @(posedge clk);
            #1;
            model_step(r, e, c, int'(s));
        end
    endtask

    task automatic chk(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = {clk_out, tick, spe_act, beat_cnt};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got clk_out=%b tick=%b spe_act=%0d beat=%0d, expected clk_out=%b tick=%b spe_act=%0d beat=%0d",
                     name, got[7], got[6], got[5:4], got[3:0], exp[7], exp[6], exp[5:4], exp[3:0]);
        end
    endtask

    function automatic logic [7:0] e8(input int c, input int t, input int a, input int b);
        return {1'(c), 1'(t), 2'(a), 4'(b)};
    endfunction

    initial begin
        // {rst, en, clr, spe, cycles, expected {clk_out, tick, spe_act, beat}}
        // spe = 0 run: H = 8, rising edges at enabled cycles 8, 24, 40
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 1,  e8(0, 0, 0, 0)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 7,  e8(0, 0, 0, 0)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 1,  e8(1, 1, 0, 1)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 1,  e8(1, 0, 0, 1)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 7,  e8(0, 0, 0, 1)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 8,  e8(1, 1, 0, 2)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 16, e8(1, 1, 0, 3)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 8,  e8(0, 0, 0, 3)});
        // spe = 3 from reset: first half-period still 8, then H = 1; 20 ticks wrap beat to 4
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd3, 1,  e8(0, 0, 0, 0)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd3, 8,  e8(1, 1, 3, 1)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd3, 1,  e8(0, 0, 3, 1)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd3, 1,  e8(1, 1, 3, 2)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd3, 36, e8(1, 1, 3, 4)});
        // pause at cnt = 5 for 5 cycles, then 3 more enabled cycles finish the half-period
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 1,  e8(0, 0, 0, 0)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 5,  e8(0, 0, 0, 0)});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 5,  e8(0, 0, 0, 0)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 2,  e8(0, 0, 0, 0)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 1,  e8(1, 1, 0, 1)});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 3,  e8(1, 0, 0, 1)});

        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].s, tbl[i].n);
            chk($sformatf("tbl[%0d]", i), tbl[i].exp);
        end

        // Rate change 0 -> 1 three cycles into a half-period
        run(1, 0, 0, 0, 1);
        run(0, 1, 0, 0, 3);
        run(0, 1, 0, 1, 4);
        chk("rate_hold_old", e8(0, 0, 0, 0));
        run(0, 1, 0, 1, 1);
        chk("rate_boundary", e8(1, 1, 1, 1));
        run(0, 1, 0, 1, 3);
        chk("rate_new_mid", e8(1, 0, 1, 1));
        run(0, 1, 0, 1, 1);
        chk("rate_new_fall", e8(0, 0, 1, 1));
        run(0, 1, 0, 1, 4);
        chk("rate_new_rise", e8(1, 1, 1, 2));

        // clr on a terminal cycle with clk_out low
        run(1, 0, 0, 0, 1);
        run(0, 1, 0, 0, 7);
        run(0, 1, 1, 2, 1);
        chk("clr_on_term", e8(0, 0, 2, 0));
        run(0, 1, 0, 2, 1);
        chk("clr_cnt_zero", e8(0, 0, 2, 0));
        run(0, 1, 0, 2, 1);
        chk("clr_then_rise", e8(1, 1, 2, 1));

        // rst mid-high-phase with spe = 2
        run(1, 0, 0, 2, 1);
        run(0, 1, 0, 2, 9);
        chk("pre_rst_high", e8(1, 0, 2, 1));
        run(1, 1, 0, 2, 1);
        chk("rst_mid_high", e8(0, 0, 0, 0));
        run(0, 1, 0, 2, 7);
        chk("rst_first_half", e8(0, 0, 0, 0));
        run(0, 1, 0, 2, 1);
        chk("rst_first_rise", e8(1, 1, 2, 1));

        // Randomized run against the model
        run(1, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            logic r, e, c;
            logic [1:0] s;
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 3) != 0);
            s = 2'($urandom_range(0, 3));
            run(r, e, c, s, 1);
            chk($sformatf("rand[%0d]", i), e8(m_lvl, m_tick, m_act, m_beat));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
